wall_follow: RTL and testbench
==============================

WALL_FOLLOW -- requirements
Module: wall_follow

Interface
REQ-001 Parameter FRONT_STOP, default 12, front distance (inches) below which the path is blocked.
REQ-002 Parameter FRONT_CRASH, default 5, front distance below which the block backs off first.
REQ-003 Parameter SIDE_NEAR, default 6, and SIDE_FAR, default 14: allowed band for left-wall distance.
REQ-004 Parameter ANGLE_TOL, default 5, largest ANGLE treated as aligned.
REQ-005 Parameter PERSIST, default 3, consecutive blocked ticks before acting (1..7).
REQ-006 Parameter TURN_TICKS, default 8, and BACKOFF_TICKS, default 4: manoeuvre durations in ticks (1..255).
REQ-007 CLK  in  1  system clock; clock is one single clock domain.
REQ-008 RST_N  in  1  reset, asynchronous, active-low.
REQ-009 SAMPLE_TICK  in  1  one-cycle strobe, CLK-synchronous; new sensor data is valid.
REQ-010 ENABLE  in  1  autonomous mode on.
REQ-011 DISTANCE_FRONT, DISTANCE_BACK, DISTANCE_SIDE_FRONT, DISTANCE_SIDE_BACK  in  8 each  inches; 0 = no echo.
REQ-012 ANGLE  in  8  magnitude of body-to-wall angle; ANGLE_DIRECTION  in  2  00 aligned, 01 nose toward wall, 10 nose away, 11 invalid.
REQ-013 DIR_STATE  out  5  direction command to the motor direction controller.
REQ-014 PWM_STATE  out  5  power command to the motor direction controller.
REQ-015 NAV_STATE  out  3  current FSM state encoding, for display and debug.

Function
REQ-016 The block evaluates all inputs only in the cycle SAMPLE_TICK=1; between ticks the state and counters hold, except for ENABLE handling in REQ-025.
REQ-017 A distance of 0 is replaced by 255 before any comparison.
REQ-018 Side distance = (SIDE_FRONT + SIDE_BACK) >> 1, computed 9-bit then truncated to 8 bits.
REQ-019 Front-block filter: 3-bit saturating counter. It increments on a tick with front < FRONT_STOP and clears on a tick with front >= FRONT_STOP. "Blocked" = counter >= PERSIST, including the current tick's increment.
REQ-020 States: IDLE, CRUISE, CORRECT_R, CORRECT_L, BACKOFF, PIVOT_R.
REQ-021 Transition priority on a tick, from CRUISE, CORRECT_R or CORRECT_L:
  - Blocked and front < FRONT_CRASH -> BACKOFF.
  - Otherwise blocked -> PIVOT_R.
  - Otherwise side < SIDE_NEAR, or (ANGLE > ANGLE_TOL and dir = 01) -> CORRECT_R.
  - Otherwise side > SIDE_FAR, or (ANGLE > ANGLE_TOL and dir = 10) -> CORRECT_L.
  - Otherwise -> CRUISE.
REQ-022 ANGLE_DIRECTION = 11 is treated as aligned.
REQ-023 BACKOFF loads an 8-bit tick counter with BACKOFF_TICKS on entry, decrements it per tick, and goes to PIVOT_R when the counter reaches 0. If DISTANCE_BACK < FRONT_CRASH on a tick, it goes to PIVOT_R immediately.
REQ-024 PIVOT_R loads the counter with TURN_TICKS on entry and goes to CRUISE when the count expires. The front filter clears on entry.
REQ-025 ENABLE=0, sampled every cycle regardless of SAMPLE_TICK, forces IDLE at the next edge and clears the counters. From IDLE, a tick with ENABLE=1 -> CRUISE.
REQ-026 Outputs are registered, driven from the next-state decode, and change on the same edge as the state register. Latency is tick cycle N -> new outputs at edge N+1.
REQ-027 Output table (DIR_STATE / PWM_STATE):
  - IDLE: 00000 / 00000.
  - CRUISE: 00001 / 10111.
  - CORRECT_R: 00011 / 01111.
  - CORRECT_L: 11000 / 01111.
  - BACKOFF: 00010 / 00111.
  - PIVOT_R: 10011 / 01011.
REQ-028 NAV_STATE encodings: IDLE 0, CRUISE 1, CORRECT_R 2, CORRECT_L 3, BACKOFF 4, PIVOT_R 5.

Reset
REQ-029 While RST_N=0, all of the following are forced immediately, asynchronously: state IDLE, DIR_STATE 00000, PWM_STATE 00000, NAV_STATE 0, filter and tick counters 0.
REQ-030 Reset mid-manoeuvre abandons the manoeuvre. After release, the block leaves IDLE only on the first tick with ENABLE=1.

Structure
REQ-031 Shared package nav_pkg holds:
  - the DIR_STATE encodings (NEUTRAL, FORWARD, REVERSE, FORWARD_RIGHT, BACK_RIGHT, FORWARD_LEFT, BACK_LEFT, R_360, L_360);
  - the PWM encodings (BOTH_100 down to BOTH_17);
  - the state encoding.
REQ-032 One sub-module, persist_filter, implements the saturating front-block counter of REQ-019.

Verification
REQ-033 Reset with ENABLE=1, then one tick with front=40, side=10/10, ANGLE=0 -> one cycle later CRUISE, DIR 00001, PWM 10111.
REQ-034 In CRUISE, front=10 for 2 ticks -> stays CRUISE. On the 3rd tick -> PIVOT_R (10011/01011). It returns to CRUISE after exactly 8 further ticks.
REQ-035 In CRUISE, side 4/4 -> CORRECT_R. Side 20/20 -> CORRECT_L. Side 10/10 with ANGLE=9, dir=10 -> CORRECT_L. Side 10/10 with ANGLE=9, dir=11 -> CRUISE.
REQ-036 Front=3 for 3 ticks -> BACKOFF (00010/00111) for 4 ticks, then PIVOT_R. Repeat with back=2 on the first BACKOFF tick -> PIVOT_R immediately.
REQ-037 ENABLE dropped mid-PIVOT_R with no tick -> IDLE and 00000/00000 next edge. Separately, RST_N pulsed mid-BACKOFF -> outputs 0 asynchronously.
REQ-038 A distance of 0 on all sensors -> treated as 255, so the block goes to CORRECT_L with no block.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared navigation encodings: motor direction/power commands and the wall-follow state set.
// Also holds the command lookup for each state and the no-echo substitution.
package nav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CRUISE    = 3'd1,
    ST_CORRECT_R = 3'd2,
    ST_CORRECT_L = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_PIVOT_R   = 3'd5
  } nav_state_e;

  localparam logic [4:0] DIR_NEUTRAL       = 5'b00000;
  localparam logic [4:0] DIR_FORWARD       = 5'b00001;
  localparam logic [4:0] DIR_REVERSE       = 5'b00010;
  localparam logic [4:0] DIR_FORWARD_RIGHT = 5'b00011;
  localparam logic [4:0] DIR_BACK_RIGHT    = 5'b00100;
  localparam logic [4:0] DIR_FORWARD_LEFT  = 5'b11000;
  localparam logic [4:0] DIR_BACK_LEFT     = 5'b10100;
  localparam logic [4:0] DIR_R_360         = 5'b10011;
  localparam logic [4:0] DIR_L_360         = 5'b11011;

  localparam logic [4:0] PWM_OFF      = 5'b00000;
  localparam logic [4:0] PWM_BOTH_100 = 5'b10111;
  localparam logic [4:0] PWM_BOTH_83  = 5'b01111;
  localparam logic [4:0] PWM_BOTH_67  = 5'b01011;
  localparam logic [4:0] PWM_BOTH_50  = 5'b00111;
  localparam logic [4:0] PWM_BOTH_33  = 5'b00011;
  localparam logic [4:0] PWM_BOTH_17  = 5'b00001;

  // A zero reading means no echo, i.e. nothing in range.
  function automatic logic [7:0] no_echo(input logic [7:0] d);
    return (d == 8'd0) ? 8'hFF : d;
  endfunction

  function automatic logic [4:0] dir_of(input nav_state_e s);
    logic [4:0] r;
    case (s)
      ST_CRUISE:    r = DIR_FORWARD;
      ST_CORRECT_R: r = DIR_FORWARD_RIGHT;
      ST_CORRECT_L: r = DIR_FORWARD_LEFT;
      ST_BACKOFF:   r = DIR_REVERSE;
      ST_PIVOT_R:   r = DIR_R_360;
      default:      r = DIR_NEUTRAL;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] pwm_of(input nav_state_e s);
    logic [4:0] r;
    case (s)
      ST_CRUISE:    r = PWM_BOTH_100;
      ST_CORRECT_R: r = PWM_BOTH_83;
      ST_CORRECT_L: r = PWM_BOTH_83;
      ST_BACKOFF:   r = PWM_BOTH_50;
      ST_PIVOT_R:   r = PWM_BOTH_67;
      default:      r = PWM_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/persist_filter.sv
// Saturating 3-bit count of consecutive blocked samples; blocked reflects the
// current sample's update so the decision is not delayed by a tick.
module persist_filter #(
  parameter logic [2:0] PERSIST = 3'd3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic below,
  input  logic clear,
  output logic blocked
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_upd;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_upd = cnt_q;
    if (tick) begin
      if (below) begin
        cnt_upd = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
      end else begin
        cnt_upd = 3'd0;
      end
    end
    // clear feeds only the register, never blocked, so no loop through the FSM.
    cnt_d   = clear ? 3'd0 : cnt_upd;
    blocked = tick && (cnt_upd >= PERSIST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wall_follow.sv
// Left-wall following navigator: filters the front sensor, keeps the side distance
// in band and runs timed back-off / pivot manoeuvres, issuing registered motor commands.
module wall_follow
  import nav_pkg::*;
#(
  parameter logic [7:0] FRONT_STOP    = 8'd12,
  parameter logic [7:0] FRONT_CRASH   = 8'd5,
  parameter logic [7:0] SIDE_NEAR     = 8'd6,
  parameter logic [7:0] SIDE_FAR      = 8'd14,
  parameter logic [7:0] ANGLE_TOL     = 8'd5,
  parameter logic [2:0] PERSIST       = 3'd3,
  parameter logic [7:0] TURN_TICKS    = 8'd8,
  parameter logic [7:0] BACKOFF_TICKS = 8'd4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SAMPLE_TICK,
  input  logic       ENABLE,
  input  logic [7:0] DISTANCE_FRONT,
  input  logic [7:0] DISTANCE_BACK,
  input  logic [7:0] DISTANCE_SIDE_FRONT,
  input  logic [7:0] DISTANCE_SIDE_BACK,
  input  logic [7:0] ANGLE,
  input  logic [1:0] ANGLE_DIRECTION,
  output logic [4:0] DIR_STATE,
  output logic [4:0] PWM_STATE,
  output logic [2:0] NAV_STATE
);

  nav_state_e state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [4:0] dir_q, pwm_q;

  logic [7:0] front_s, back_s, side_s;
  logic [8:0] side_sum;
  logic       blocked;
  logic       filt_clear;
  logic       nose_toward, nose_away;

  always_comb begin
    front_s  = no_echo(DISTANCE_FRONT);
    back_s   = no_echo(DISTANCE_BACK);
    side_sum = {1'b0, no_echo(DISTANCE_SIDE_FRONT)} + {1'b0, no_echo(DISTANCE_SIDE_BACK)};
    side_s   = side_sum[8:1];
    // Direction code 11 is invalid and falls through as aligned.
    nose_toward = (ANGLE > ANGLE_TOL) && (ANGLE_DIRECTION == 2'b01);
    nose_away   = (ANGLE > ANGLE_TOL) && (ANGLE_DIRECTION == 2'b10);
  end

  persist_filter #(
    .PERSIST(PERSIST)
  ) u_front_filter (
    .clk    (CLK),
    .rst_n  (RST_N),
    .tick   (SAMPLE_TICK && ENABLE),
    .below  (front_s < FRONT_STOP),
    .clear  (filt_clear),
    .blocked(blocked)
  );

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    filt_clear = 1'b0;
    if (!ENABLE) begin
      state_d    = ST_IDLE;
      tcnt_d     = 8'd0;
      filt_clear = 1'b1;
    end else if (SAMPLE_TICK) begin
      case (state_q)
        ST_IDLE: state_d = ST_CRUISE;
        ST_CRUISE, ST_CORRECT_R, ST_CORRECT_L: begin
          if (blocked && (front_s < FRONT_CRASH)) begin
            state_d = ST_BACKOFF;
            tcnt_d  = BACKOFF_TICKS;
          end else if (blocked) begin
            state_d    = ST_PIVOT_R;
            tcnt_d     = TURN_TICKS;
            filt_clear = 1'b1;
          end else if ((side_s < SIDE_NEAR) || nose_toward) begin
            state_d = ST_CORRECT_R;
          end else if ((side_s > SIDE_FAR) || nose_away) begin
            state_d = ST_CORRECT_L;
          end else begin
            state_d = ST_CRUISE;
          end
        end
        ST_BACKOFF: begin
          // Something close behind cuts the back-off short.
          if ((back_s < FRONT_CRASH) || (tcnt_q <= 8'd1)) begin
            state_d    = ST_PIVOT_R;
            tcnt_d     = TURN_TICKS;
            filt_clear = 1'b1;
          end else begin
            tcnt_d = tcnt_q - 8'd1;
          end
        end
        ST_PIVOT_R: begin
          if (tcnt_q <= 8'd1) begin
            state_d = ST_CRUISE;
            tcnt_d  = 8'd0;
          end else begin
            tcnt_d = tcnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Commands are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tcnt_q  <= 8'd0;
      dir_q   <= DIR_NEUTRAL;
      pwm_q   <= PWM_OFF;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      dir_q   <= dir_of(state_d);
      pwm_q   <= pwm_of(state_d);
    end
  end

  assign DIR_STATE = dir_q;
  assign PWM_STATE = pwm_q;
  assign NAV_STATE = state_q;

endmodule

// File: tb/tb_wall_follow.sv
// Scoreboarded bench for wall_follow: directed scenarios plus random sensor traffic,
// checked cycle by cycle against a rule-level reference model.
module tb_wall_follow;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SAMPLE_TICK = 1'b0;
  logic       ENABLE = 1'b0;
  logic [7:0] DISTANCE_FRONT = 8'd40, DISTANCE_BACK = 8'd40;
  logic [7:0] DISTANCE_SIDE_FRONT = 8'd10, DISTANCE_SIDE_BACK = 8'd10;
  logic [7:0] ANGLE = 8'd0;
  logic [1:0] ANGLE_DIRECTION = 2'b00;
  logic [4:0] DIR_STATE, PWM_STATE;
  logic [2:0] NAV_STATE;

  wall_follow dut (
    .CLK(CLK), .RST_N(RST_N), .SAMPLE_TICK(SAMPLE_TICK), .ENABLE(ENABLE),
    .DISTANCE_FRONT(DISTANCE_FRONT), .DISTANCE_BACK(DISTANCE_BACK),
    .DISTANCE_SIDE_FRONT(DISTANCE_SIDE_FRONT), .DISTANCE_SIDE_BACK(DISTANCE_SIDE_BACK),
    .ANGLE(ANGLE), .ANGLE_DIRECTION(ANGLE_DIRECTION),
    .DIR_STATE(DIR_STATE), .PWM_STATE(PWM_STATE), .NAV_STATE(NAV_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         step;
    int         nav;
    logic [4:0] dir;
    logic [4:0] pwm;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  // Reference model state: 0 IDLE,1 CRUISE,2 CORRECT_R,3 CORRECT_L,4 BACKOFF,5 PIVOT_R
  int m_st = 0, m_filt = 0, m_tcnt = 0;
  logic [4:0] dir_tab [6] = '{5'b00000, 5'b00001, 5'b00011, 5'b11000, 5'b00010, 5'b10011};
  logic [4:0] pwm_tab [6] = '{5'b00000, 5'b10111, 5'b01111, 5'b01111, 5'b00111, 5'b01011};

  function automatic int fix(input int d);
    return (d == 0) ? 255 : d;
  endfunction

  task automatic model(input bit tick, input bit en, input int fr, input int bk,
                       input int sf, input int sb, input int ang, input int ad);
    int f, b, side;
    bit blocked;
    if (!en) begin
      m_st = 0; m_filt = 0; m_tcnt = 0;
      return;
    end
    if (!tick) return;
    f = fix(fr);
    b = fix(bk);
    side = (fix(sf) + fix(sb)) / 2;
    m_filt = (f < 12) ? ((m_filt < 7) ? m_filt + 1 : 7) : 0;
    blocked = (m_filt >= 3);
    case (m_st)
      0: m_st = 1;
      1, 2, 3: begin
        if (blocked && f < 5) begin m_st = 4; m_tcnt = 4; end
        else if (blocked) begin m_st = 5; m_tcnt = 8; m_filt = 0; end
        else if (side < 6 || (ang > 5 && ad == 1)) m_st = 2;
        else if (side > 14 || (ang > 5 && ad == 2)) m_st = 3;
        else m_st = 1;
      end
      4: begin
        m_tcnt = m_tcnt - 1;
        if (b < 5 || m_tcnt == 0) begin m_st = 5; m_tcnt = 8; m_filt = 0; end
      end
      5: begin
        m_tcnt = m_tcnt - 1;
        if (m_tcnt == 0) m_st = 1;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic step(input bit tick, input bit en, input int fr, input int bk,
                      input int sf, input int sb, input int ang, input int ad);
    exp_t e;
    @(negedge CLK);
    SAMPLE_TICK = tick;
    ENABLE = en;
    DISTANCE_FRONT = fr[7:0];
    DISTANCE_BACK = bk[7:0];
    DISTANCE_SIDE_FRONT = sf[7:0];
    DISTANCE_SIDE_BACK = sb[7:0];
    ANGLE = ang[7:0];
    ANGLE_DIRECTION = ad[1:0];
    model(tick, en, fr, bk, sf, sb, ang, ad);
    step_no++;
    e.step = step_no;
    e.nav = m_st;
    e.dir = dir_tab[m_st];
    e.pwm = pwm_tab[m_st];
    exp_q.push_back(e);
  endtask

  task automatic tk(input int fr, input int bk, input int sf, input int sb,
                    input int ang, input int ad);
    step(1'b1, 1'b1, fr, bk, sf, sb, ang, ad);
    step(1'b0, 1'b1, fr, bk, sf, sb, ang, ad);
  endtask

  task automatic chk_zero(input string name);
    tests++;
    if (NAV_STATE !== 3'd0 || DIR_STATE !== 5'd0 || PWM_STATE !== 5'd0) begin
      fails++;
      $display("FAIL %s: nav/dir/pwm got %0d/%b/%b, required 0/00000/00000",
               name, NAV_STATE, DIR_STATE, PWM_STATE);
    end
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic reset_pulse(input bit en_after, input string name);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk_zero(name);
    m_st = 0; m_filt = 0; m_tcnt = 0;
    @(negedge CLK);
    SAMPLE_TICK = 1'b0;
    ENABLE = en_after;
    RST_N = 1'b1;
  endtask

  // Monitor: outputs settle on every edge, so each driven cycle yields one comparison.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (NAV_STATE !== e.nav[2:0] || DIR_STATE !== e.dir || PWM_STATE !== e.pwm) begin
          fails++;
          $display("FAIL step %0d outputs: nav/dir/pwm got %0d/%b/%b, required %0d/%b/%b",
                   e.step, NAV_STATE, DIR_STATE, PWM_STATE, e.nav, e.dir, e.pwm);
        end
      end
    end
  end

  function automatic int rd();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return 0;
    if (k <= 6) return int'($urandom_range(1, 20));
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    ENABLE = 1'b1;
    RST_N = 1'b0;
    #12;
    chk_zero("reset_state");
    @(negedge CLK);
    RST_N = 1'b1;

    // First tick leaves IDLE.
    tk(40, 40, 10, 10, 0, 0);
    step(1'b0, 1'b1, 40, 40, 10, 10, 0, 0);
    // Persistence then timed pivot.
    tk(10, 40, 10, 10, 0, 0);
    tk(10, 40, 10, 10, 0, 0);
    tk(10, 40, 10, 10, 0, 0);
    for (int i = 0; i < 9; i++) tk(40, 40, 10, 10, 0, 0);
    // Side and angle corrections.
    tk(40, 40, 4, 4, 0, 0);
    tk(40, 40, 20, 20, 0, 0);
    tk(40, 40, 10, 10, 9, 2);
    tk(40, 40, 10, 10, 9, 3);
    tk(40, 40, 10, 10, 9, 1);
    tk(40, 40, 10, 10, 5, 1);
    // Crash back-off, full duration then short-cut by the rear sensor.
    for (int i = 0; i < 3; i++) tk(3, 40, 10, 10, 0, 0);
    for (int i = 0; i < 5; i++) tk(40, 40, 10, 10, 0, 0);
    for (int i = 0; i < 9; i++) tk(40, 40, 10, 10, 0, 0);
    for (int i = 0; i < 3; i++) tk(3, 40, 10, 10, 0, 0);
    tk(40, 2, 10, 10, 0, 0);
    // Enable drop mid-pivot without a tick.
    tk(40, 40, 10, 10, 0, 0);
    step(1'b0, 1'b0, 40, 40, 10, 10, 0, 0);
    step(1'b0, 1'b1, 40, 40, 10, 10, 0, 0);
    tk(40, 40, 10, 10, 0, 0);
    // Async reset mid-back-off.
    for (int i = 0; i < 3; i++) tk(3, 40, 10, 10, 0, 0);
    tk(40, 40, 10, 10, 0, 0);
    reset_pulse(1'b1, "async_reset_backoff");
    step(1'b0, 1'b1, 40, 40, 10, 10, 0, 0);
    // No echo anywhere reads as far away.
    tk(40, 40, 10, 10, 0, 0);
    tk(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit tick, en;
      int fr;
      tick = ($urandom_range(0, 2) != 0);
      en = ($urandom_range(0, 59) != 0);
      fr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 13)) : rd();
      step(tick, en, fr, rd(), rd(), rd(), int'($urandom_range(0, 12)),
           int'($urandom_range(0, 3)));
      if (i % 1000 == 999) reset_pulse(1'b1, "async_reset_random");
    end

    step(1'b0, 1'b1, 40, 40, 10, 10, 0, 0);
    @(posedge CLK);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending got %0d, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
